// File: rtl/hp_vpu_pkg.sv
// Hyperplane VPU shared types and constants.
// Holds the CV-X-IF result bundle layout and its defaults.
package hp_vpu_pkg;

    localparam int XIF_ID_W = 4;
    localparam int XIF_XLEN = 32;

    localparam logic [5:0] XIF_EXC_ILLEGAL = 6'd2;

    typedef struct packed {
        logic [XIF_ID_W-1:0] id;
        logic [XIF_XLEN-1:0] data;
        logic [4:0]          rd;
        logic                we;
        logic                exc;
        logic [5:0]          exccode;
    } xif_result_t;

endpackage

// File: rtl/hp_vpu_sync_fifo.sv
// Synchronous FIFO with a combinational head read port.
// Full and empty are told apart by an extra pointer bit.
module hp_vpu_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head  = mem[rptr[AW-1:0]];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rptr <= rptr + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/hp_vpu_xif_result.sv
// CV-X-IF result transmitter: buffers completions and releases
// them only once the CPU has committed; killed ones are dropped.
module hp_vpu_xif_result
    import hp_vpu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int ID_W  = XIF_ID_W,
    parameter int XLEN  = XIF_XLEN
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            cpl_valid_i,
    output logic            cpl_ready_o,
    input  logic [ID_W-1:0] cpl_id_i,
    input  logic [XLEN-1:0] cpl_data_i,
    input  logic [4:0]      cpl_rd_i,
    input  logic            cpl_we_i,
    input  logic            cpl_exc_i,
    input  logic [5:0]      cpl_exccode_i,
    input  logic            commit_valid_i,
    input  logic [ID_W-1:0] commit_id_i,
    input  logic            commit_kill_i,
    output logic            result_valid_o,
    input  logic            result_ready_i,
    output logic [ID_W-1:0] result_id_o,
    output logic [XLEN-1:0] result_data_o,
    output logic [4:0]      result_rd_o,
    output logic            result_we_o,
    output logic            result_exc_o,
    output logic [5:0]      result_exccode_o,
    output logic            idle_o
);

    localparam int NID = 1 << ID_W;

    // Same layout as xif_result_t, at this instance's widths.
    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [XLEN-1:0] data;
        logic [4:0]      rd;
        logic            we;
        logic            exc;
        logic [5:0]      exccode;
    } entry_t;

    entry_t         wr_entry;
    entry_t         head;
    entry_t         head_out;
    logic           full;
    logic           empty;
    logic           push;
    logic           pop;
    logic           drop;
    logic           head_cv;
    logic           head_kill;
    logic [NID-1:0] sb_valid;
    logic [NID-1:0] sb_kill;
    logic [NID-1:0] in_buf;

    assign wr_entry = '{id: cpl_id_i, data: cpl_data_i, rd: cpl_rd_i,
                        we: cpl_we_i, exc: cpl_exc_i,
                        exccode: cpl_exccode_i};

    assign cpl_ready_o = !full;
    assign push        = cpl_valid_i && !full;

    hp_vpu_sync_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push   (push),
        .wdata  (wr_entry),
        .pop    (pop),
        .head   (head),
        .full   (full),
        .empty  (empty)
    );

    assign head_cv   = sb_valid[head.id];
    assign head_kill = sb_kill[head.id];

    assign drop           = !empty && head_cv && head_kill;
    assign result_valid_o = !empty && head_cv && !head_kill;
    assign pop            = drop || (result_valid_o && result_ready_i);

    // Keep stale memory contents off the port while the buffer is empty.
    assign head_out = empty ? '0 : head;

    assign result_id_o      = head_out.id;
    assign result_data_o    = head_out.data;
    assign result_rd_o      = head_out.rd;
    assign result_we_o      = head_out.we && !head_out.exc;
    assign result_exc_o     = head_out.exc;
    assign result_exccode_o = head_out.exccode;

    assign idle_o = empty && !(|sb_valid);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sb_valid <= '0;
            sb_kill  <= '0;
            in_buf   <= '0;
        end else begin
            if (pop) begin
                sb_valid[head.id] <= 1'b0;
                in_buf[head.id]   <= 1'b0;
            end
            if (commit_valid_i) begin
                sb_valid[commit_id_i] <= 1'b1;
                sb_kill[commit_id_i]  <= commit_kill_i;
            end
            if (push) in_buf[cpl_id_i] <= 1'b1;
        end
    end

    always @(posedge clk_i) begin
        if (rst_ni) begin
            if (commit_valid_i)
                assert (!sb_valid[commit_id_i])
                else $error("xif_result: commit to busy id %0d",
                            commit_id_i);
            if (push)
                assert (!in_buf[cpl_id_i] ||
                        (pop && head.id == cpl_id_i))
                else $error("xif_result: duplicate completion id %0d",
                            cpl_id_i);
        end
    end

endmodule

// File: doc/hp_vpu_xif_result.md
# hp_vpu_xif_result

CV-X-IF result-interface transmitter for the Hyperplane VPU. It buffers in-order completions from the vector pipeline and tracks CPU commit/kill decisions per instruction ID. It returns a result to the CPU only for committed, non-killed instructions, and drops killed ones silently. It sits between the pipeline writeback stage and the core's result port, as the return path for instructions accepted at issue.

## Interface
- `DEPTH`, default 4: completion buffer entries; power of two, ≥2.
- `ID_W`, default 4: CV-X-IF instruction ID width.
- `XLEN`, default 32: scalar result width.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous assert, active-low.
- `cpl_valid_i` in 1: pipeline completion valid.
- `cpl_ready_o` out 1: buffer can accept a completion.
- `cpl_id_i` in ID_W: completing instruction ID.
- `cpl_data_i` in XLEN: scalar rd data (vmv.x.s, vcpop, vfirst, vsetvl*).
- `cpl_rd_i` in 5: destination x-register.
- `cpl_we_i` in 1: instruction writes rd.
- `cpl_exc_i` in 1: instruction raised an exception.
- `cpl_exccode_i` in 6: exception code.
- `commit_valid_i` in 1: commit-interface transaction.
- `commit_id_i` in ID_W: ID being committed or killed.
- `commit_kill_i` in 1: 1 = kill, 0 = commit.
- `result_valid_o` out 1: result offered to the CPU.
- `result_ready_i` in 1: CPU accepts the result.
- `result_id_o` out ID_W: result ID.
- `result_data_o` out XLEN: rd data.
- `result_rd_o` out 5: rd index.
- `result_we_o` out 1: write enable; forced 0 when `result_exc_o` = 1.
- `result_exc_o` out 1: exception flag.
- `result_exccode_o` out 6: exception code.
- `idle_o` out 1: buffer empty and no scoreboard entry valid.

## Operation
- **Completion buffer:** a FIFO of DEPTH entries holding {id, data, rd, we, exc, exccode}.
  - Push on `cpl_valid_i && cpl_ready_o`.
  - `cpl_ready_o = !full`. A slot freed by a pop this cycle does not make `cpl_ready_o` high in the same cycle.
- **Commit scoreboard:** 2^ID_W entries of {valid, kill}, indexed by ID.
  - `commit_valid_i` sets `valid=1` and `kill=commit_kill_i` at the clock edge.
  - The new entry is visible the next cycle; there is no same-cycle bypass.
  - A commit may arrive before or after the matching completion.
- **Head resolution, evaluated each cycle on the FIFO head when the buffer is not empty:**
  - Scoreboard[head.id] not valid → wait; `result_valid_o` = 0.
  - Valid and kill = 1 → pop the head and clear scoreboard[head.id]; `result_valid_o` = 0 this cycle; one entry is dropped per cycle.
  - Valid and kill = 0 → `result_valid_o` = 1. On `result_ready_i`, pop and clear scoreboard[head.id].
- **Output sourcing:** result fields come combinationally from the head entry.
  - `result_we_o = head.we && !head.exc`.
- **Protocol errors (assertion only, no recovery):**
  - Commit to an ID whose scoreboard entry is already valid.
  - Completion whose ID equals an ID already present in the buffer.

## Timing
- Reset values:
  - `result_valid_o` = 0, `cpl_ready_o` = 1, `idle_o` = 1.
  - All data outputs = 0.
  - FIFO pointers and count cleared; all scoreboard valid bits cleared.
- Reset mid-operation discards all buffered and committed state with no results emitted.
- Minimum latency is 1 cycle:
  - A completion pushed at edge N, with commit registered at or before N, gives `result_valid_o` = 1 in cycle N+1.
  - A commit registered at edge N for a waiting head gives `result_valid_o` in cycle N+1.
- Once `result_valid_o` = 1, it and all result fields stay stable until `result_ready_i`. They cannot be withdrawn; a later kill to a committed ID is a protocol error.
- Back-to-back: with committed entries queued and `result_ready_i` held at 1, one result is emitted per cycle.
- Simultaneous push and pop on a non-full buffer is legal; the count is unchanged.
- Simultaneous commit of ID A and pop/clear of ID B ≠ A both take effect. A commit to the ID being cleared in the same cycle is a protocol error.
- Pointers wrap modulo DEPTH. Full/empty are distinguished by an extra pointer bit.

## Structure
- **hp_vpu_pkg gains:**
  - `xif_result_t`, a packed struct {id, data, rd, we, exc, exccode}.
  - `XIF_ID_W` default.
  - `XIF_EXC_ILLEGAL` exccode constant.
- **Sub-module `hp_vpu_sync_fifo`:**
  - Parameterised width and depth; async active-low reset.
  - Ports `push`/`pop`/`full`/`empty`, with a head read port.
  - Instantiated once with `$bits(xif_result_t)`.
- Scoreboard and head-resolution logic are local to `hp_vpu_xif_result`.

## Test plan
- **Commit before completion:** commit id=3 (kill=0), then completion id=3 with data 0x0000_00A5, rd=10, we=1 → the next cycle gives `result_valid_o`=1, id=3, data=0xA5, rd=10, we=1; with ready=1 the buffer goes idle.
- **Kill:** completions id=1 and id=2, commit id=1 kill=1, commit id=2 kill=0 → no result for id=1; id=2 is emitted one cycle after id=1 is dropped.
- **Backpressure and full:** 4 completions with `result_ready_i`=0 and all committed → `cpl_ready_o`=0 after the 4th. id0's fields stay stable for 10 cycles. Releasing ready emits ids 0–3 on consecutive cycles.
- **Exception:** completion id=5 with exc=1, exccode=2, we=1, committed → `result_exc_o`=1, `result_exccode_o`=2, `result_we_o`=0.
- **Reset mid-operation:** 3 buffered entries with 2 committed; assert `rst_ni` low asynchronously → `result_valid_o` drops to 0 immediately. After release, `idle_o`=1 and a new completion id=0 waits for its commit.
- **Wrap-around:** stream 20 committed completions with ids cycling 0–15 and random ready → all 20 are emitted in order with data intact.
